// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for a ROWS x COLS weight-stationary systolic array.
// Loads weights row by row, then drives skewed activation-read enables and
// per-column result-valid strobes that track the 2-stage PE pipeline.
module systolic_seq_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    w_load_en,
  output logic [$clog2(ROWS)-1:0] w_row_sel,
  output logic [ROWS-1:0]         act_rd_en,
  output logic [KW-1:0]           act_k_base,
  output logic [COLS-1:0]         out_valid
);

  localparam int RSW = $clog2(ROWS);
  // Wide enough for T_LAST at the largest k_len, so nothing ever wraps.
  localparam int TW  = KW + $clog2(ROWS + COLS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [TW-1:0] cnt;
  logic [TW-1:0] t_last;
  logic [TW-1:0] t_next;

  assign t_last = TW'(k_reg) + TW'(COLS + ROWS - 1);
  assign t_next = cnt + TW'(1);

  // Lane r injects vectors 0..k-1 starting r cycles after lane 0.
  function automatic logic [ROWS-1:0] lane_en(input logic [TW-1:0] tv,
                                              input logic [KW-1:0] kv);
    logic [ROWS-1:0] en;
    en = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      en[r] = (tv >= TW'(r)) && ((tv - TW'(r)) < TW'(kv));
    end
    return en;
  endfunction

  // Column c sees results ROWS+1 cycles (row skew + PE latency) plus c
  // cycles of horizontal activation shift after lane 0 starts.
  function automatic logic [COLS-1:0] col_en(input logic [TW-1:0] tv,
                                             input logic [KW-1:0] kv);
    logic [COLS-1:0] en;
    en = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      en[c] = (tv >= TW'(c + ROWS + 1)) &&
              ((tv - TW'(c + ROWS + 1)) < TW'(kv));
    end
    return en;
  endfunction

  // Lane-0 vector index, saturating at the last vector once lane 0 is done.
  function automatic logic [KW-1:0] kbase(input logic [TW-1:0] tv,
                                          input logic [KW-1:0] kv);
    return (tv < TW'(kv)) ? tv[KW-1:0] : (kv - KW'(1));
  endfunction

  // Sequencer FSM; every output is registered with the value for the
  // state being entered, so outputs line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k_reg      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      w_load_en  <= 1'b0;
      w_row_sel  <= '0;
      act_rd_en  <= '0;
      act_k_base <= '0;
      out_valid  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              state     <= LOAD_W;
              k_reg     <= k_len;
              cnt       <= '0;
              busy      <= 1'b1;
              w_load_en <= 1'b1;
              w_row_sel <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (cnt == TW'(ROWS - 1)) begin
            state      <= RUN;
            cnt        <= '0;
            w_load_en  <= 1'b0;
            w_row_sel  <= '0;
            act_rd_en  <= lane_en('0, k_reg);
            act_k_base <= kbase('0, k_reg);
            out_valid  <= col_en('0, k_reg);
          end else begin
            cnt       <= t_next;
            w_row_sel <= t_next[RSW-1:0];
          end
        end
        RUN: begin
          if (cnt == t_last) begin
            state     <= DONE;
            done      <= 1'b1;
            act_rd_en <= '0;
            out_valid <= '0;
          end else begin
            cnt        <= t_next;
            act_rd_en  <= lane_en(t_next, k_reg);
            act_k_base <= kbase(t_next, k_reg);
            out_valid  <= col_en(t_next, k_reg);
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          cnt        <= '0;
          act_k_base <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with ROWS=COLS=4, KW=9.
// Cycle n of a tile is the interval after edge n-1, where edge 0 accepts start.
module tb_systolic_seq_ctrl;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 9;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          w_load_en;
  logic [1:0]    w_row_sel;
  logic [R-1:0]  act_rd_en;
  logic [KW-1:0] act_k_base;
  logic [C-1:0]  out_valid;

  int passed = 0;
  int total  = 0;

  systolic_seq_ctrl #(.ROWS(R), .COLS(C), .KW(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .w_load_en  (w_load_en),
    .w_row_sel  (w_row_sel),
    .act_rd_en  (act_rd_en),
    .act_k_base (act_k_base),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int cyc);
    chk({tag, "_busy"}, cyc, 32'(busy), 0);
    chk({tag, "_done"}, cyc, 32'(done), 0);
    chk({tag, "_err"},  cyc, 32'(err), 0);
    chk({tag, "_wld"},  cyc, 32'(w_load_en), 0);
    chk({tag, "_wsel"}, cyc, 32'(w_row_sel), 0);
    chk({tag, "_act"},  cyc, 32'(act_rd_en), 0);
    chk({tag, "_kb"},   cyc, 32'(act_k_base), 0);
    chk({tag, "_ov"},   cyc, 32'(out_valid), 0);
  endtask

  // Expected outputs in tile cycle c, written from the cycle-level timing.
  task automatic check_cycle(input string tag, input int c, input int k);
    int d;
    int t;
    logic [R-1:0] e_act;
    logic [C-1:0] e_ov;
    d = 2*R + C + k + 1;
    t = c - R - 1;
    e_act = '0;
    e_ov  = '0;
    if (c >= R + 1 && c <= d - 1) begin
      for (int r = 0; r < R; r++)
        if (t >= r && t - r < k) e_act[r] = 1'b1;
      for (int cc = 0; cc < C; cc++)
        if (t >= cc + R + 1 && t - cc - R - 1 < k) e_ov[cc] = 1'b1;
      chk({tag, "_kb"}, c, 32'(act_k_base), (t < k) ? t : k - 1);
    end
    chk({tag, "_busy"}, c, 32'(busy), 32'(c >= 1 && c <= d));
    chk({tag, "_done"}, c, 32'(done), 32'(c == d));
    chk({tag, "_err"},  c, 32'(err), 0);
    chk({tag, "_wld"},  c, 32'(w_load_en), 32'(c >= 1 && c <= R));
    if (c >= 1 && c <= R) chk({tag, "_wsel"}, c, 32'(w_row_sel), c - 1);
    chk({tag, "_act"},  c, 32'(act_rd_en), 32'(e_act));
    chk({tag, "_ov"},   c, 32'(out_valid), 32'(e_ov));
  endtask

  initial begin
    int max_kb;
    int last_ov3;
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    step();
    step();
    chk_idle("reset", 0);
    rst = 1'b0;
    step();

    // Scenario 1: k_len=3 tile with hand-checked overlap points.
    start = 1'b1;
    k_len = 9'd3;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check_cycle("s1", c, 3);
      if (c == 5)  chk("s1_act_first", c, 32'(act_rd_en), 32'b0001);
      if (c == 8)  chk("s1_act_mid",   c, 32'(act_rd_en), 32'b1110);
      if (c == 10) chk("s1_act_ovl",   c, 32'(act_rd_en), 32'b1000);
      if (c == 10) chk("s1_ov_ovl",    c, 32'(out_valid), 32'b0001);
      if (c == 13) chk("s1_ov_mid",    c, 32'(out_valid), 32'b1110);
      if (c == 16) chk("s1_done",      c, 32'(done), 1);
      if (c < 17) step();
    end

    // Scenario 2: zero-length request is rejected with an err pulse.
    start = 1'b1;
    k_len = '0;
    step();
    start = 1'b0;
    chk("s2_err",  1, 32'(err), 1);
    chk("s2_busy", 1, 32'(busy), 0);
    chk("s2_wld",  1, 32'(w_load_en), 0);
    chk("s2_act",  1, 32'(act_rd_en), 0);
    chk("s2_ov",   1, 32'(out_valid), 0);
    chk("s2_done", 1, 32'(done), 0);
    step();
    chk_idle("s2_after", 2);

    // Scenario 3: single-vector tile.
    start = 1'b1;
    k_len = 9'd1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check_cycle("s3", c, 1);
      if (c == 8)  chk("s3_act3", c, 32'(act_rd_en), 32'b1000);
      if (c == 13) chk("s3_ov3",  c, 32'(out_valid), 32'b1000);
      if (c < 15) step();
    end
    step();

    // Scenario 4: stray starts and k_len changes mid-tile are ignored;
    // start held across DONE launches the next tile one idle cycle later.
    start = 1'b1;
    k_len = 9'd3;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check_cycle("s4", c, 3);
      if (c == 3)  begin start = 1'b1; k_len = 9'd7; end
      if (c == 4)  start = 1'b0;
      if (c == 9)  start = 1'b1;
      if (c == 10) start = 1'b0;
      if (c == 16) begin start = 1'b1; k_len = 9'd2; end
      if (c < 17) step();
    end
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check_cycle("s4b", c, 2);
      if (c < 16) step();
    end

    // Scenario 5: synchronous reset abandons a tile, then a clean restart.
    start = 1'b1;
    k_len = 9'd3;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check_cycle("s5", c, 3);
      if (c < 7) step();
    end
    rst = 1'b1;
    step();
    chk_idle("s5_rst", 8);
    rst   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check_cycle("s5b", c, 3);
      if (c < 17) step();
    end

    // Scenario 6: maximum depth, no counter wrap.
    start = 1'b1;
    k_len = 9'd511;
    step();
    start = 1'b0;
    max_kb   = 0;
    last_ov3 = -1;
    for (int c = 1; c <= 525; c++) begin
      check_cycle("s6", c, 511);
      if (int'(act_k_base) > max_kb) max_kb = int'(act_k_base);
      if (out_valid[3]) last_ov3 = c;
      if (c < 525) step();
    end
    chk("s6_kb_max",   525, max_kb, 510);
    chk("s6_ov3_last", 525, last_ov3, R + 1 + 518);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
